// File: rtl/product_accumulator_if.sv
// Handshake bundle between the product source, the accumulator and the consumer.
// The master drives products and accepts sums; the slave is the accumulator.
interface product_accumulator_if #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;
  logic             busy;

  modport master (
    output start,
    output len,
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_sum,
    input  out_ovf,
    input  busy
  );

  modport slave (
    input  start,
    input  len,
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_sum,
    output out_ovf,
    output busy
  );
endinterface

// File: rtl/product_accumulator.sv
// Sums a programmed number of unsigned products into a saturating accumulator.
// The result is held on a valid/ready port with a sticky overflow flag.
module product_accumulator #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input logic                   clk,
  input logic                   rst,
  product_accumulator_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [ACC_W-1:0] acc_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [ACC_W:0]   sum_d;
  logic             beat;
  logic             sat;

  // One extra bit catches the carry out of the accumulator.
  assign sum_d = {1'b0, acc_q}
               + {{(ACC_W + 1 - IN_W){1'b0}}, bus.in_data};
  assign beat  = bus.in_valid & in_ready_q;
  assign sat   = sum_d[ACC_W] | ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            acc_q  <= '0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b1;
            if (bus.len != '0) begin
              cnt_q      <= bus.len;
              state_q    <= ACCUM;
              in_ready_q <= 1'b1;
            end else begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (beat) begin
            cnt_q <= cnt_q - 1'b1;
            if (sat) begin
              acc_q <= '1;
              ovf_q <= 1'b1;
            end else begin
              acc_q <= sum_d[ACC_W-1:0];
            end
            if (cnt_q == CNT_W'(1)) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = acc_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator with a 20-bit accumulator.
// Expected sums are queued as runs are started and popped as results emerge.
module tb_product_accumulator;

  localparam int IN_W  = 16;
  localparam int ACC_W = 20;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  product_accumulator_if #(
    .IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)
  ) bus ();

  product_accumulator #(
    .IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [ACC_W-1:0] exp_sum_q[$];
  logic             exp_ovf_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
  endtask

  task automatic start_run(input int n, input logic [ACC_W-1:0] s,
                           input logic o, input logic push);
    if (push) begin
      exp_sum_q.push_back(s);
      exp_ovf_q.push_back(o);
    end
    bus.start = 1'b1;
    bus.len   = CNT_W'(n);
    tick();
    bus.start = 1'b0;
    bus.len   = '0;
  endtask

  task automatic send_beat(input logic [IN_W-1:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic collect(input string name);
    int n;
    logic [ACC_W-1:0] es;
    logic eo;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    total++;
    if (bus.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s timeout: out_valid=%b want 1", name, bus.out_valid);
    end
    total++;
    if (exp_sum_q.size() == 0) begin
      bad++;
      $display("FAIL %s scoreboard empty: got sum=%h want none", name, bus.out_sum);
    end else begin
      es = exp_sum_q.pop_front();
      eo = exp_ovf_q.pop_front();
      if (bus.out_sum !== es) begin
        bad++;
        $display("FAIL %s sum: got %h want %h", name, bus.out_sum, es);
      end
      total++;
      if (bus.out_ovf !== eo) begin
        bad++;
        $display("FAIL %s ovf: got %b want %b", name, bus.out_ovf, eo);
      end
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s drop: out_valid=%b want 0", name, bus.out_valid);
    end
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL %s busy after: got %b want 0", name, bus.busy);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    total++;
    if ({bus.in_ready, bus.out_valid, bus.out_sum, bus.out_ovf, bus.busy} !== '0) begin
      bad++;
      $display("FAIL %s: rdy=%b vld=%b sum=%h ovf=%b busy=%b want all 0",
               name, bus.in_ready, bus.out_valid, bus.out_sum,
               bus.out_ovf, bus.busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.start     = 1'($urandom);
      bus.len       = CNT_W'($urandom);
      bus.in_valid  = 1'($urandom);
      bus.in_data   = IN_W'($urandom);
      bus.out_ready = 1'($urandom);
      tick();
      check_zero_outputs("reset_held");
    end
    idle_inputs();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_zero_outputs("reset_released");
    end
  endtask

  task automatic test_basic();
    start_run(4, 20'h3F804, 1'b0, 1'b1);
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL basic in_ready: got %b want 1", bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hFE01;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (bus.out_valid !== 1'b0) begin
        bad++;
        $display("FAIL basic early valid beat%0d: got %b want 0", i, bus.out_valid);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    total++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL basic latency: vld=%b rdy=%b want 1 0",
               bus.out_valid, bus.in_ready);
    end
    collect("basic");
  endtask

  task automatic test_gaps();
    start_run(3, 20'd6, 1'b0, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      send_beat(IN_W'(i));
      if (i < 3) begin
        tick();
        tick();
      end
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_sum !== 20'd6) begin
        bad++;
        $display("FAIL gaps hold%0d: vld=%b sum=%h want 1 000006",
                 i, bus.out_valid, bus.out_sum);
      end
      tick();
    end
    collect("gaps");
  endtask

  task automatic test_overflow();
    start_run(17, 20'hFFFFF, 1'b1, 1'b1);
    for (int i = 0; i < 17; i++) send_beat(16'hFFFF);
    collect("overflow");
    start_run(1, 20'd5, 1'b0, 1'b1);
    send_beat(16'h0005);
    collect("after_overflow");
  endtask

  task automatic test_edge();
    start_run(0, 20'd0, 1'b0, 1'b1);
    total++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL len0: vld=%b rdy=%b want 1 0", bus.out_valid, bus.in_ready);
    end
    collect("len0");
    start_run(3, 20'd60, 1'b0, 1'b1);
    send_beat(16'd10);
    bus.start = 1'b1;
    bus.len   = 8'd1;
    tick();
    bus.start = 1'b0;
    bus.len   = '0;
    send_beat(16'd20);
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_start count: vld=%b rdy=%b want 0 1",
               bus.out_valid, bus.in_ready);
    end
    send_beat(16'd30);
    collect("mid_start");
  endtask

  task automatic test_abort();
    start_run(4, '0, 1'b0, 1'b0);
    send_beat(16'h1234);
    send_beat(16'h1234);
    rst = 1'b1;
    #1;
    check_zero_outputs("abort_async");
    tick();
    rst = 1'b0;
    tick();
    check_zero_outputs("abort_idle");
    start_run(1, 20'd7, 1'b0, 1'b1);
    send_beat(16'h0007);
    collect("after_abort");
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic();
    test_gaps();
    test_overflow();
    test_edge();
    test_abort();
    total++;
    if (exp_sum_q.size() != 0) begin
      bad++;
      $display("FAIL leftover: got %0d queued want 0", exp_sum_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
